// File: rtl/bcd_digit_entry.sv
// -----------------------------------------------------------------------------
// bcd_digit_entry
//
// Multi-digit BCD entry register for the temperature/value input path.
// Digits are taken from the switches, ones digit first, one per rising edge
// of the (already debounced) enter button. When the final digit is accepted
// the whole number is committed to current_value and the previous committed
// number moves to old_value.
//
// Parameters:
//   NUM_DIGITS     digits per entry (1..8)
//   IDX_W          digit-index width, 2**IDX_W >= NUM_DIGITS
//   TIMEOUT_CYCLES idle cycles before a partial entry is aborted
//                  (used only when BCD_ENTRY_TIMEOUT_EN is defined)
//
// Optional feature macro: BCD_ENTRY_TIMEOUT_EN
//   Defined   : an idle counter aborts a partial entry and pulses 'timeout'.
//   Undefined : no counter, no 'timeout' port; a partial entry persists.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   enter         in   debounced button level, only its rising edge acts
//   cancel        in   synchronous level, discards the partial entry
//   value         in   digit on the switches
//   input_state   out  index of the next digit to enter (0 = ones)
//   partial_value out  digits accepted so far, unentered digits are 0
//   current_value out  last committed number, ones digit in [3:0]
//   old_value     out  number committed before current_value
//   commit        out  one-cycle pulse after a commit
//   digit_err     out  one-cycle pulse after a rejected (>9) digit
//   timeout       out  one-cycle pulse after an idle abort (macro only)
// -----------------------------------------------------------------------------
module bcd_digit_entry #(
  parameter int NUM_DIGITS     = 3,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enter,
  input  logic                    cancel,
  input  logic [3:0]              value,
  output logic [IDX_W-1:0]        input_state,
  output logic [4*NUM_DIGITS-1:0] partial_value,
  output logic [4*NUM_DIGITS-1:0] current_value,
  output logic [4*NUM_DIGITS-1:0] old_value,
  output logic                    commit,
`ifdef BCD_ENTRY_TIMEOUT_EN
  output logic                    timeout,
`endif
  output logic                    digit_err
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Elaboration-time guard against an unusable parameter set.
  if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8) || ((2 ** IDX_W) < NUM_DIGITS) ||
      (TIMEOUT_CYCLES < 2)) begin : g_bad_params
    $error("bcd_digit_entry: illegal parameter combination");
  end

  logic             enter_q;
  logic             armed_q, armed_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VW-1:0]    partial_q, partial_d;
  logic [VW-1:0]    current_q, current_d;
  logic [VW-1:0]    old_q, old_d;
  logic             commit_q, commit_d;
  logic             err_q, err_d;

  logic             ep_s;
  logic             digit_ok_s;
  logic             abort_s;
  logic [VW-1:0]    inserted_s;

`ifdef BCD_ENTRY_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Abort fires on the edge after the idle counter has reached its last value.
  assign abort_s = (idx_q != {IDX_W{1'b0}}) && (cnt_q == CNT_LAST);

  // Idle counter: only runs while an entry is in progress.
  always_comb begin
    cnt_d = cnt_q;
    if ((idx_q == {IDX_W{1'b0}}) || cancel || ep_s || abort_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Idle counter and timeout pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign abort_s = 1'b0;
`endif

  // Rising-edge detect. armed_q stays low after reset until enter has been
  // seen low, so a button already held through reset release does not count.
  assign ep_s       = enter & ~enter_q & armed_q;
  assign armed_d    = armed_q | ~enter;
  assign digit_ok_s = (value <= 4'd9);

  // Partial value with the current digit dropped into its slot.
  always_comb begin
    inserted_s = partial_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        inserted_s[4*i +: 4] = value;
      end else begin
        inserted_s[4*i +: 4] = partial_q[4*i +: 4];
      end
    end
  end

  // Next-state logic: cancel > enter edge > idle abort.
  always_comb begin
    idx_d     = idx_q;
    partial_d = partial_q;
    current_d = current_q;
    old_d     = old_q;
    commit_d  = 1'b0;
    err_d     = 1'b0;
`ifdef BCD_ENTRY_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    if (cancel) begin
      idx_d     = {IDX_W{1'b0}};
      partial_d = {VW{1'b0}};
    end else if (ep_s) begin
      if (!digit_ok_s) begin
        err_d = 1'b1;
      end else if (idx_q == LAST_IDX) begin
        current_d = inserted_s;
        old_d     = current_q;
        partial_d = {VW{1'b0}};
        idx_d     = {IDX_W{1'b0}};
        commit_d  = 1'b1;
      end else begin
        partial_d = inserted_s;
        idx_d     = idx_q + IDX_W'(1);
      end
    end else if (abort_s) begin
      idx_d     = {IDX_W{1'b0}};
      partial_d = {VW{1'b0}};
`ifdef BCD_ENTRY_TIMEOUT_EN
      timeout_d = 1'b1;
`endif
    end else begin
      idx_d = idx_q;
    end
  end

  // Entry state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enter_q   <= 1'b0;
      armed_q   <= 1'b0;
      idx_q     <= {IDX_W{1'b0}};
      partial_q <= {VW{1'b0}};
      current_q <= {VW{1'b0}};
      old_q     <= {VW{1'b0}};
      commit_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      enter_q   <= enter;
      armed_q   <= armed_d;
      idx_q     <= idx_d;
      partial_q <= partial_d;
      current_q <= current_d;
      old_q     <= old_d;
      commit_q  <= commit_d;
      err_q     <= err_d;
    end
  end

  assign input_state   = idx_q;
  assign partial_value = partial_q;
  assign current_value = current_q;
  assign old_value     = old_q;
  assign commit        = commit_q;
  assign digit_err     = err_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// -----------------------------------------------------------------------------
// tb_bcd_digit_entry
//
// Self-checking bench for bcd_digit_entry (3 digits). Each cycle the bench
// predicts the registered outputs from its own behavioural model, queues the
// prediction, and compares it after the clock edge. Fixed values from the
// entry scenarios are checked on top of that.
// -----------------------------------------------------------------------------
module tb_bcd_digit_entry;

  localparam int ND = 3;
  localparam int IW = 2;
  localparam int TO = 8;
  localparam int VW = 4 * ND;

  typedef struct {
    logic [IW-1:0] idx;
    logic [VW-1:0] part;
    logic [VW-1:0] cur;
    logic [VW-1:0] old;
    logic          commit;
    logic          err;
    logic          tmo;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          enter;
  logic          cancel;
  logic [3:0]    value;
  logic [IW-1:0] input_state;
  logic [VW-1:0] partial_value;
  logic [VW-1:0] current_value;
  logic [VW-1:0] old_value;
  logic          commit;
  logic          digit_err;
`ifdef BCD_ENTRY_TIMEOUT_EN
  logic          timeout;
`endif

  int n_vec;
  int n_err;
  exp_t sb_q[$];

  // Bench model state
  logic          m_enter_q;
  logic          m_armed;
  logic [IW-1:0] m_idx;
  logic [VW-1:0] m_part;
  logic [VW-1:0] m_cur;
  logic [VW-1:0] m_old;
`ifdef BCD_ENTRY_TIMEOUT_EN
  int            m_cnt;
`endif

  bcd_digit_entry #(
    .NUM_DIGITS    (ND),
    .IDX_W         (IW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enter        (enter),
    .cancel       (cancel),
    .value        (value),
    .input_state  (input_state),
    .partial_value(partial_value),
    .current_value(current_value),
    .old_value    (old_value),
    .commit       (commit),
`ifdef BCD_ENTRY_TIMEOUT_EN
    .timeout      (timeout),
`endif
    .digit_err    (digit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_enter_q = 1'b0;
    m_armed   = 1'b0;
    m_idx     = '0;
    m_part    = '0;
    m_cur     = '0;
    m_old     = '0;
`ifdef BCD_ENTRY_TIMEOUT_EN
    m_cnt     = 0;
`endif
  endtask

  // Predict the registered outputs after the next edge for the given inputs.
  task automatic model_step(input logic en, input logic can, input logic [3:0] val);
    exp_t e;
    logic ep;
    logic abort;
    logic [IW-1:0] idx_before;
    ep = en & ~m_enter_q & m_armed;
    idx_before = m_idx;
    abort = 1'b0;
`ifdef BCD_ENTRY_TIMEOUT_EN
    abort = (m_idx != 0) && (m_cnt == TO - 1);
`endif
    e.commit = 1'b0;
    e.err    = 1'b0;
    e.tmo    = 1'b0;
    if (can) begin
      m_idx  = '0;
      m_part = '0;
    end else if (ep) begin
      if (val > 4'd9) begin
        e.err = 1'b1;
      end else if (m_idx == IW'(ND - 1)) begin
        m_old    = m_cur;
        m_cur    = m_part | (VW'(val) << (4 * m_idx));
        m_part   = '0;
        m_idx    = '0;
        e.commit = 1'b1;
      end else begin
        m_part = m_part | (VW'(val) << (4 * m_idx));
        m_idx  = m_idx + 1'b1;
      end
    end else if (abort) begin
      m_idx  = '0;
      m_part = '0;
      e.tmo  = 1'b1;
    end
`ifdef BCD_ENTRY_TIMEOUT_EN
    if (idx_before == 0 || can || ep || abort) m_cnt = 0;
    else m_cnt = m_cnt + 1;
`endif
    if (!en) m_armed = 1'b1;
    m_enter_q = en;
    e.idx  = m_idx;
    e.part = m_part;
    e.cur  = m_cur;
    e.old  = m_old;
    sb_q.push_back(e);
  endtask

  // One clock: drive on the falling edge, compare 1 time unit after the rise.
  task automatic cycle(input logic en, input logic can, input logic [3:0] val);
    exp_t e;
    @(negedge clk);
    enter  = en;
    cancel = can;
    value  = val;
    model_step(en, can, val);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("sb_idx", 32'(input_state), 32'(e.idx));
      check_eq("sb_part", 32'(partial_value), 32'(e.part));
      check_eq("sb_cur", 32'(current_value), 32'(e.cur));
      check_eq("sb_old", 32'(old_value), 32'(e.old));
      check_eq("sb_commit", 32'(commit), 32'(e.commit));
      check_eq("sb_err", 32'(digit_err), 32'(e.err));
`ifdef BCD_ENTRY_TIMEOUT_EN
      check_eq("sb_tmo", 32'(timeout), 32'(e.tmo));
`endif
    end
  endtask

  task automatic press(input logic [3:0] val);
    cycle(1'b1, 1'b0, val);
    cycle(1'b0, 1'b0, val);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_idx"}, 32'(input_state), 32'd0);
    check_eq({tag, "_part"}, 32'(partial_value), 32'd0);
    check_eq({tag, "_cur"}, 32'(current_value), 32'd0);
    check_eq({tag, "_old"}, 32'(old_value), 32'd0);
    check_eq({tag, "_commit"}, 32'(commit), 32'd0);
    check_eq({tag, "_err"}, 32'(digit_err), 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    enter  = 1'b0;
    cancel = 1'b0;
    value  = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 4'd0);

    // 3,2,1 ones first -> 123
    press(4'd3);
    press(4'd2);
    cycle(1'b1, 1'b0, 4'd1);
    check_eq("c123_commit_hi", 32'(commit), 32'd1);
    check_eq("c123_cur", 32'(current_value), 32'h123);
    check_eq("c123_old", 32'(old_value), 32'h0);
    check_eq("c123_idx", 32'(input_state), 32'd0);
    cycle(1'b0, 1'b0, 4'd0);
    check_eq("c123_commit_lo", 32'(commit), 32'd0);

    // 555 then 001
    press(4'd5); press(4'd5); press(4'd5);
    check_eq("c555_cur", 32'(current_value), 32'h555);
    check_eq("c555_old", 32'(old_value), 32'h123);
    press(4'd1); press(4'd0); press(4'd0);
    check_eq("c001_cur", 32'(current_value), 32'h001);
    check_eq("c001_old", 32'(old_value), 32'h555);

    // enter held high for 10 cycles -> one digit
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 4'd4);
    check_eq("hold_idx", 32'(input_state), 32'd1);
    check_eq("hold_part", 32'(partial_value), 32'h004);
    cycle(1'b0, 1'b1, 4'd0);
    check_eq("cancel0_idx", 32'(input_state), 32'd0);

    // 7, bad digit B, then 8, 9 -> 987
    press(4'd7);
    cycle(1'b1, 1'b0, 4'hB);
    check_eq("bad_err", 32'(digit_err), 32'd1);
    check_eq("bad_idx", 32'(input_state), 32'd1);
    check_eq("bad_part", 32'(partial_value), 32'h007);
    cycle(1'b0, 1'b0, 4'hB);
    check_eq("bad_err_lo", 32'(digit_err), 32'd0);
    press(4'd8);
    press(4'd9);
    check_eq("c987_cur", 32'(current_value), 32'h987);
    check_eq("c987_old", 32'(old_value), 32'h001);

    // 2,6 then cancel together with an enter edge
    press(4'd2);
    press(4'd6);
    check_eq("pre_cancel_part", 32'(partial_value), 32'h062);
    cycle(1'b1, 1'b1, 4'd3);
    check_eq("cancel_idx", 32'(input_state), 32'd0);
    check_eq("cancel_part", 32'(partial_value), 32'h0);
    check_eq("cancel_cur", 32'(current_value), 32'h987);
    check_eq("cancel_commit", 32'(commit), 32'd0);
    cycle(1'b0, 1'b0, 4'd0);

`ifdef BCD_ENTRY_TIMEOUT_EN
    // one digit then idle: abort on the 8th edge after the enter edge
    press(4'd3);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 4'd0);
    check_eq("tmo_pre_idx", 32'(input_state), 32'd1);
    check_eq("tmo_pre", 32'(timeout), 32'd0);
    cycle(1'b0, 1'b0, 4'd0);
    check_eq("tmo_pulse", 32'(timeout), 32'd1);
    check_eq("tmo_idx", 32'(input_state), 32'd0);
    check_eq("tmo_cur", 32'(current_value), 32'h987);
    cycle(1'b0, 1'b0, 4'd0);
    check_eq("tmo_lo", 32'(timeout), 32'd0);
    // enter edge at cycle 7 restarts the idle count
    press(4'd3);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd5);
    check_eq("notmo_pulse", 32'(timeout), 32'd0);
    check_eq("notmo_idx", 32'(input_state), 32'd2);
    cycle(1'b0, 1'b1, 4'd0);
`endif

    // reset mid-entry clears everything asynchronously
    press(4'd4);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 4'd0);
    press(4'd6);
    check_eq("post_rst_idx", 32'(input_state), 32'd1);
    check_eq("post_rst_part", 32'(partial_value), 32'h006);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
